// File: rtl/sha_arbiter.sv
// sha_arbiter: round-robin owner lock in front of a single SHA compression core.
// One requester keeps the core from its first block to its last block. The
// arbiter sequences first/continue for each block and returns the final digest
// tagged with the owner id.
//
// state | meaning
// IDLE  | no owner; search requesters starting at rr_ptr
// ISSUE | owner locked; start the core as soon as the owner offers a block
// WAIT  | compression in flight; wait for core_ready
// DONE  | one-cycle digest strobe; advance rr_ptr past the owner
`timescale 1ns/1ps
module sha_arbiter #(
  parameter int NREQ = 4,
  parameter int Nb   = 512,
  parameter int Nh   = 256,
  parameter int Nid  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*Nb-1:0] req_block,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  output logic              core_enable,
  output logic              core_function,
  output logic [Nb-1:0]     core_data,
  input  logic              core_ready,
  input  logic [Nh-1:0]     core_hash,
  output logic              done_valid,
  output logic [Nid-1:0]    done_id,
  output logic [Nh-1:0]     done_hash,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [Nid-1:0]  owner;
  logic [Nid-1:0]  rr_ptr;
  logic            first;
  logic            last_q;

  logic [Nid-1:0]  pick;
  logic            pick_found;
  logic [Nid:0]    cand;
  logic [NREQ-1:0] owner_oh;
  logic            issue_fire;
  logic [Nid-1:0]  owner_next;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (Nid+1)'(i);
      if (cand >= (Nid+1)'(NREQ)) cand = cand - (Nid+1)'(NREQ);
      if (!pick_found && req_valid[cand[Nid-1:0]]) begin
        pick       = cand[Nid-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Owner decode and the single-cycle core start handshake.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    issue_fire      = (state == ISSUE) && req_valid[owner];
    grant           = ((state == ISSUE) || (state == WAIT)) ? owner_oh : '0;
    req_ack         = issue_fire ? owner_oh : '0;
    core_enable     = issue_fire;
    core_function   = issue_fire & ~first;
    core_data       = issue_fire ? req_block[owner*Nb +: Nb] : '0;
    busy            = (state != IDLE);
    owner_next      = (owner == Nid'(NREQ-1)) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM, message lock and digest capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      first      <= 1'b1;
      last_q     <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_hash  <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick;
            first <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The lock is held indefinitely while the owner has no block ready.
          if (issue_fire) begin
            last_q <= req_last[owner];
            first  <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (core_ready) begin
            if (last_q) begin
              done_hash  <= core_hash;
              done_id    <= owner;
              done_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: begin
          rr_ptr <= owner_next;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_arbiter.sv
// tb_sha_arbiter: directed stimulus for sha_arbiter with a queue scoreboard.
// Stimulus pushes the expected core starts and digests; a negedge monitor pops
// and compares whenever the DUT strobes core_enable or done_valid.
`timescale 1ns/1ps
module tb_sha_arbiter;
  localparam int NREQ = 4;
  localparam int NB   = 512;
  localparam int NH   = 256;
  localparam int NID  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*NB-1:0]   req_block = '0;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      grant;
  logic                 core_enable;
  logic                 core_function;
  logic [NB-1:0]        core_data;
  logic                 core_ready = 1'b0;
  logic [NH-1:0]        core_hash = '0;
  logic                 done_valid;
  logic [NID-1:0]       done_id;
  logic [NH-1:0]        done_hash;
  logic                 busy;

  sha_arbiter #(.NREQ(NREQ), .Nb(NB), .Nh(NH), .Nid(NID)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_block(req_block), .req_ack(req_ack), .grant(grant),
    .core_enable(core_enable), .core_function(core_function),
    .core_data(core_data), .core_ready(core_ready), .core_hash(core_hash),
    .done_valid(done_valid), .done_id(done_id), .done_hash(done_hash),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic func; logic [NB-1:0] data; } iss_t;
  typedef struct { int id; logic [NH-1:0] hash; } dn_t;
  iss_t iss_q[$];
  dn_t  dn_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [NB-1:0] blk(int n);
    logic [NB-1:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = 32'hC0DE0000 ^ 32'(n*16 + k);
    return b;
  endfunction

  function automatic logic [NH-1:0] hv(int n);
    logic [NH-1:0] h;
    for (int k = 0; k < 8; k++) h[k*32 +: 32] = 32'hB0000000 | 32'(n*8 + k);
    return h;
  endfunction

  function automatic logic [NREQ-1:0] oh(int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  iss_t mon_i;
  dn_t  mon_d;
  always @(negedge clk) begin
    if (rst) begin
      check("grant_onehot", NB'($countones(grant) <= 1), NB'(1));
      if (core_enable) begin
        if (iss_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_enable: got ack=%b expected no core start", req_ack);
        end else begin
          mon_i = iss_q.pop_front();
          check("core_function", NB'(core_function), NB'(mon_i.func));
          check("core_data", core_data, mon_i.data);
          check("req_ack", NB'(req_ack), NB'(oh(mon_i.id)));
          check("grant", NB'(grant), NB'(oh(mon_i.id)));
        end
      end else begin
        check("ack_idle", NB'(req_ack), '0);
      end
      if (done_valid) begin
        if (dn_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got id=%0d expected no digest", done_id);
        end else begin
          mon_d = dn_q.pop_front();
          check("done_id", NB'(done_id), NB'(mon_d.id));
          check("done_hash", NB'(done_hash), NB'(mon_d.hash));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int r, input logic [NB-1:0] b, input logic last);
    req_valid[r] = 1'b1;
    req_last[r]  = last;
    req_block[r*NB +: NB] = b;
  endtask

  // Wait (bounded) for the owner ack, then withdraw the block after that edge.
  task automatic take(input int r);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (req_ack[r]) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: got no ack for requester %0d expected ack", r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic pulse(input int d, input logic [NH-1:0] h);
    repeat (d) tick();
    core_ready = 1'b1;
    core_hash  = h;
    tick();
    core_ready = 1'b0;
    core_hash  = '0;
  endtask

  task automatic push_i(input int id, input logic func, input logic [NB-1:0] data);
    iss_t e;
    e.id = id; e.func = func; e.data = data;
    iss_q.push_back(e);
  endtask

  task automatic push_d(input int id, input logic [NH-1:0] h);
    dn_t e;
    e.id = id; e.hash = h;
    dn_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, NB'(grant), '0);
    check({tag, "_req_ack"}, NB'(req_ack), '0);
    check({tag, "_core_enable"}, NB'(core_enable), '0);
    check({tag, "_core_function"}, NB'(core_function), '0);
    check({tag, "_core_data"}, core_data, '0);
    check({tag, "_done_valid"}, NB'(done_valid), '0);
    check({tag, "_done_id"}, NB'(done_id), '0);
    check({tag, "_done_hash"}, NB'(done_hash), '0);
    check({tag, "_busy"}, NB'(busy), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // Single requester 0, one block, slow core
    push_i(0, 1'b0, blk(1));
    offer(0, blk(1), 1'b1);
    tick();
    check("req_to_enable", NB'(core_enable), NB'(1));
    take(0);
    push_d(0, hv(1));
    pulse(64, hv(1));
    check("done_latency", NB'(done_valid), NB'(1));
    tick();
    check("done_pulse_width", NB'(done_valid), '0);
    check("done_hash_held", NB'(done_hash), NB'(hv(1)));
    check("idle_busy", NB'(busy), '0);

    // Requester 2, three-block message
    push_i(2, 1'b0, blk(10));
    push_i(2, 1'b1, blk(11));
    push_i(2, 1'b1, blk(12));
    for (int k = 0; k < 3; k++) begin
      offer(2, blk(10 + k), (k == 2));
      take(2);
      if (k == 2) push_d(2, hv(2));
      pulse(3 + k, (k == 2) ? hv(2) : hv(20 + k));
    end
    tick(); tick();

    // Requesters 0,1,3 valid together straight after reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    push_i(0, 1'b0, blk(30));
    push_i(1, 1'b0, blk(31));
    push_i(3, 1'b0, blk(33));
    offer(0, blk(30), 1'b1);
    offer(1, blk(31), 1'b1);
    offer(3, blk(33), 1'b1);
    take(0); push_d(0, hv(30)); pulse(3, hv(30));
    take(1); push_d(1, hv(31)); pulse(3, hv(31));
    take(3); push_d(3, hv(33)); pulse(3, hv(33));
    tick();

    // Pointer wrapped back to 0: requester 0 beats requester 2
    push_i(0, 1'b0, blk(40));
    push_i(2, 1'b0, blk(42));
    offer(0, blk(40), 1'b1);
    offer(2, blk(42), 1'b1);
    take(0); push_d(0, hv(40)); pulse(2, hv(40));
    take(2); push_d(2, hv(42)); pulse(2, hv(42));
    tick();

    // Requester 1 stalls mid-message while requester 0 waits
    push_i(1, 1'b0, blk(50));
    offer(1, blk(50), 1'b0);
    take(1);
    pulse(2, hv(51));
    offer(0, blk(60), 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_grant", NB'(grant), NB'(4'b0010));
    end
    push_i(1, 1'b1, blk(52));
    push_i(0, 1'b0, blk(60));
    offer(1, blk(52), 1'b1);
    take(1); push_d(1, hv(52)); pulse(2, hv(52));
    take(0); push_d(0, hv(60)); pulse(2, hv(60));
    tick();

    // Spurious core_ready in IDLE, then in ISSUE
    core_ready = 1'b1; core_hash = hv(99);
    tick();
    core_ready = 1'b0; core_hash = '0;
    check("spur_idle_busy", NB'(busy), '0);
    tick();
    push_i(3, 1'b0, blk(70));
    offer(3, blk(70), 1'b0);
    take(3);
    pulse(2, hv(71));
    core_ready = 1'b1; core_hash = hv(98);
    tick();
    core_ready = 1'b0; core_hash = '0;
    check("spur_issue_busy", NB'(busy), NB'(1));
    check("spur_issue_grant", NB'(grant), NB'(4'b1000));
    push_i(3, 1'b1, blk(72));
    offer(3, blk(72), 1'b1);
    take(3); push_d(3, hv(72)); pulse(2, hv(72));
    tick();

    // Asynchronous reset during WAIT of block 2
    push_i(2, 1'b0, blk(80));
    push_i(2, 1'b1, blk(81));
    offer(2, blk(80), 1'b0);
    take(2);
    pulse(2, hv(80));
    offer(2, blk(81), 1'b0);
    take(2);
    tick();
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    core_ready = 1'b1; core_hash = hv(97);
    tick();
    core_ready = 1'b0; core_hash = '0;
    check("post_rst_busy", NB'(busy), '0);
    tick(); tick();
    push_i(2, 1'b0, blk(90));
    offer(2, blk(90), 1'b1);
    take(2); push_d(2, hv(90)); pulse(3, hv(90));
    tick(); tick(); tick();

    check("iss_q_drained", NB'(iss_q.size()), '0);
    check("dn_q_drained", NB'(dn_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
